// File: rtl/ps2_key_decoder_if.sv
// ps2_key_decoder_if: receiver byte strobe in, decoded key and scan-code status out
interface ps2_key_decoder_if #(parameter int NUM_KEYS = 4);
  logic                rx_done_tick;
  logic [7:0]          rx_data;
  logic [NUM_KEYS-1:0] key_held;
  logic [NUM_KEYS-1:0] key_press;
  logic [NUM_KEYS-1:0] key_release;
  logic                any_held;
  logic                code_valid;
  logic [7:0]          code_out;
  logic                code_ext;
  logic                code_break;
  logic                seq_timeout;
  modport master (
    output rx_done_tick, rx_data,
    input  key_held, key_press, key_release, any_held,
    input  code_valid, code_out, code_ext, code_break, seq_timeout
  );
  modport slave (
    input  rx_done_tick, rx_data,
    output key_held, key_press, key_release, any_held,
    output code_valid, code_out, code_ext, code_break, seq_timeout
  );
endinterface

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: PS/2 set-2 byte stream to per-key held/press/release with prefix timeout
module ps2_key_decoder #(
  parameter int                    NUM_KEYS       = 4,
  parameter logic [NUM_KEYS*9-1:0] KEY_MAP        = {9'h029, 9'h05A, 9'h01B, 9'h01C},
  parameter int                    TIMEOUT_CYCLES = 2_000_000,
  parameter int                    TO_W           = 21
) (
  input logic             clk,
  input logic             reset,
  ps2_key_decoder_if.slave bus
);
  typedef enum logic [2:0] {IDLE, GOT_E0, GOT_F0, GOT_E0F0, SKIP} state_t;
  state_t              state, state_nx;
  logic [2:0]          skip, skip_nx;
  logic [TO_W-1:0]     to_cnt;
  logic                tick, ignore, tmo, cmp, ext, brk, bat;
  logic [7:0]          d;
  logic [NUM_KEYS-1:0] match, held_nx;
  assign tick   = bus.rx_done_tick;
  assign d      = bus.rx_data;
  assign ignore = d inside {8'hE0, 8'hF0, 8'hE1, 8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'hFC, 8'h00, 8'hFF};
  assign tmo    = !tick && state != IDLE && to_cnt == TO_W'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      skip   <= '0;
      to_cnt <= '0;
    end else begin
      state  <= state_nx;
      skip   <= skip_nx;
      to_cnt <= (tick || state == IDLE || tmo) ? '0 : to_cnt + 1'b1;
    end
  end
  always_comb begin
    state_nx = state;
    skip_nx  = skip;
    if (tmo) state_nx = IDLE;
    else if (tick)
      case (state)
        IDLE: begin
          state_nx = d == 8'hE0 ? GOT_E0 : d == 8'hF0 ? GOT_F0 : d == 8'hE1 ? SKIP : IDLE;
          skip_nx  = d == 8'hE1 ? 3'd7 : skip;
        end
        GOT_E0:   state_nx = d == 8'hF0 ? GOT_E0F0 : d == 8'hE0 ? GOT_E0 : IDLE;
        GOT_F0:   state_nx = d == 8'hF0 ? GOT_F0 : IDLE;
        GOT_E0F0: state_nx = IDLE;
        SKIP: begin
          skip_nx  = skip - 3'd1;
          state_nx = skip == 3'd1 ? IDLE : SKIP;
        end
        default:  state_nx = IDLE;
      endcase
  end
  always_comb begin
    ext = state == GOT_E0 || state == GOT_E0F0;
    brk = state == GOT_F0 || state == GOT_E0F0;
    cmp = tick && (state == IDLE   ? !ignore :
                   state == GOT_E0 ? d != 8'hF0 && d != 8'hE0 :
                   state == GOT_F0 ? d != 8'hF0 :
                   state == GOT_E0F0);
    bat = tick && state == IDLE && d == 8'hAA;
    held_nx = bat ? '0 : !cmp ? bus.key_held : brk ? bus.key_held & ~match : bus.key_held | match;
  end
  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_match
    assign match[k] = cmp && KEY_MAP[9*k +: 9] == {ext, d};
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.key_held    <= '0;
      bus.key_press   <= '0;
      bus.key_release <= '0;
      bus.any_held    <= 1'b0;
      bus.code_valid  <= 1'b0;
      bus.code_out    <= '0;
      bus.code_ext    <= 1'b0;
      bus.code_break  <= 1'b0;
      bus.seq_timeout <= 1'b0;
    end else begin
      bus.key_held    <= held_nx;
      bus.any_held    <= |held_nx;
      bus.key_press   <= brk ? '0 : match & ~bus.key_held;
      bus.key_release <= brk ? match & bus.key_held : '0;
      bus.code_valid  <= cmp;
      bus.seq_timeout <= tmo;
      if (cmp) begin
        bus.code_out   <= d;
        bus.code_ext   <= ext;
        bus.code_break <= brk;
      end
    end
  end
endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb_ps2_key_decoder: directed byte sequences with hand-computed key/code expectations
module tb_ps2_key_decoder;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0, failures = 0;
  int np = 0, nr = 0, nv = 0, nt = 0;
  logic [3:0] s_press, s_rel, s_held;
  logic       s_cv, s_ext, s_brk, s_any;
  logic [7:0] s_code;
  int b_np, b_nr, b_nv, b_nt;
  ps2_key_decoder_if #(.NUM_KEYS(4)) bus ();
  ps2_key_decoder #(
    .NUM_KEYS(4),
    .KEY_MAP({9'h174, 9'h05A, 9'h01B, 9'h01C}),
    .TIMEOUT_CYCLES(50),
    .TO_W(6)
  ) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (bus.key_press[0])   np++;
    if (bus.key_release[0]) nr++;
    if (bus.code_valid)     nv++;
    if (bus.seq_timeout)    nt++;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    bus.rx_done_tick = 1'b1;
    bus.rx_data      = b;
    @(negedge clk);
    bus.rx_done_tick = 1'b0;
    s_press = bus.key_press;
    s_rel   = bus.key_release;
    s_held  = bus.key_held;
    s_cv    = bus.code_valid;
    s_code  = bus.code_out;
    s_ext   = bus.code_ext;
    s_brk   = bus.code_break;
    s_any   = bus.any_held;
    repeat (10) @(negedge clk);
  endtask
  task automatic mark();
    b_np = np; b_nr = nr; b_nv = nv; b_nt = nt;
  endtask
  initial begin
    bus.rx_done_tick = 1'b0;
    bus.rx_data      = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset_outs", {bus.key_held, bus.key_press, bus.key_release, bus.any_held, bus.code_valid,
                         bus.code_out, bus.code_ext, bus.code_break, bus.seq_timeout}, 0);
    send(8'h1C);
    check("make_press", s_press, 4'b0001);
    check("make_held", s_held, 4'b0001);
    check("make_valid", {s_cv, s_code, s_brk, s_any}, {1'b1, 8'h1C, 1'b0, 1'b1});
    check("press_one_cycle", bus.key_press, 4'b0000);
    send(8'hF0);
    check("f0_no_valid", s_cv, 1'b0);
    send(8'h1C);
    check("break_release", s_rel, 4'b0001);
    check("break_held", {s_held, s_any, s_brk, s_cv}, {4'b0000, 1'b0, 1'b1, 1'b1});
    mark();
    send(8'h1C);
    send(8'h1C);
    check("typematic_no_press", {s_press, s_cv, s_held}, {4'b0000, 1'b1, 4'b0001});
    send(8'h1C);
    send(8'hF0);
    send(8'h1C);
    check("typematic_press_cnt", np - b_np, 1);
    check("typematic_valid_cnt", nv - b_nv, 4);
    check("typematic_release_cnt", nr - b_nr, 1);
    send(8'hE0);
    send(8'h74);
    check("ext_press", s_press, 4'b1000);
    check("ext_code", {s_ext, s_code, s_brk}, {1'b1, 8'h74, 1'b0});
    send(8'hE0);
    send(8'hF0);
    send(8'h74);
    check("ext_release", {s_rel, s_ext, s_brk, s_held}, {4'b1000, 1'b1, 1'b1, 4'b0000});
    send(8'h74);
    check("plain_no_ext_key", {s_press, s_held, s_ext, s_cv}, {4'b0000, 4'b0000, 1'b0, 1'b1});
    send(8'h1C);
    check("overlap_1", {s_held, s_any}, {4'b0001, 1'b1});
    send(8'h1B);
    check("overlap_2", {s_held, s_press, s_any}, {4'b0011, 4'b0010, 1'b1});
    send(8'hF0);
    send(8'hF0);
    send(8'h1C);
    check("overlap_3", {s_held, s_rel, s_any}, {4'b0010, 4'b0001, 1'b1});
    send(8'hAA);
    check("bat_clear", {s_held, s_rel, s_any, s_cv}, {4'b0000, 4'b0000, 1'b0, 1'b0});
    mark();
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    check("pause_silent", {32'(nv - b_nv), 32'(np - b_np), 32'(nr - b_nr)} == 0, 1'b1);
    send(8'h5A);
    check("after_pause_press", {s_press, s_cv}, {4'b0100, 1'b1});
    send(8'hF0);
    send(8'h5A);
    mark();
    send(8'hF0);
    repeat (60) @(negedge clk);
    check("timeout_pulse_cnt", nt - b_nt, 1);
    check("timeout_held", bus.key_held, 4'b0000);
    send(8'h1C);
    check("after_timeout_make", {s_press, s_brk, s_held}, {4'b0001, 1'b0, 4'b0001});
    repeat (80) @(negedge clk);
    check("idle_no_timeout", nt - b_nt, 1);
    reset = 1'b1;
    @(negedge clk);
    check("reset_held_key", {bus.key_held, bus.key_press, bus.key_release, bus.any_held, bus.code_valid,
                             bus.code_out, bus.code_ext, bus.code_break, bus.seq_timeout}, 0);
    reset = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
